// File: rtl/core_pkg.sv
// core_pkg: types and helpers shared by the pipeline stage register slice.
//   de_ctrl_t  - decode-stage control bundle (12 bits); an all-zero value is a NOP
//   de_data_t  - decode-stage payload (rs1, rs2, pc, imm, pc+4, rd; 165 bits)
//   pstage_e   - occupancy state of a skid-buffered stage {EMPTY, ONE, FULL}
package core_pkg;

    typedef struct packed {
        logic       RegWrite;
        logic [1:0] ResultSrc;
        logic       MemWrite;
        logic       Jump;
        logic       Branch;
        logic [3:0] ALUControl;
        logic       ALUSrcA;
        logic       ALUSrcB;
    } de_ctrl_t;

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] pc_plus4;
        logic [4:0]  rd;
    } de_data_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pstage_e;

    localparam int DE_CTRL_W = $bits(de_ctrl_t);
    localparam int DE_DATA_W = $bits(de_data_t);

    // Number of valid entries held by a stage (0, 1 or 2).
    function automatic logic [1:0] held_count(input logic main_v, input logic skid_v);
        return {1'b0, main_v} + {1'b0, skid_v};
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// sat_counter: W-bit counter that adds an INC_W-bit increment every cycle and
// sticks at 2^W-1 instead of wrapping. Cleared only by synchronous rst.
//   clk, rst   - clock, synchronous active-high reset
//   inc_i      - amount to add this cycle
//   cnt_o      - registered count value
module sat_counter #(
    parameter int W     = 16,
    parameter int INC_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [INC_W-1:0] inc_i,
    output logic [W-1:0]     cnt_o
);

    localparam logic [W:0] MAX_C = {1'b0, {W{1'b1}}};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W:0]   sum_s;

    // One extra bit on the sum exposes overflow so it can be clamped.
    always_comb begin
        sum_s = {1'b0, cnt_q} + {{(W + 1 - INC_W){1'b0}}, inc_i};
        if (sum_s > MAX_C) begin
            cnt_d = MAX_C[W-1:0];
        end else begin
            cnt_d = sum_s[W-1:0];
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline stage register with valid/ready handshake, flush,
// optional skid buffer and saturating stall/flush counters.
//   clk, rst                     - clock, synchronous active-high reset
//   flush_i                      - discard every held entry (and this cycle's input)
//   in_valid_i/in_ready_o        - upstream handshake; in_ctrl_i/in_data_i payload
//   out_valid_o/out_ready_i      - downstream handshake
//   out_ctrl_o                   - control bundle, zero whenever no entry is presented
//   out_data_o                   - payload, passed through unmodified
//   stall_cnt_o                  - cycles presenting an entry that was not taken
//   flush_cnt_o                  - valid entries thrown away by flush
module pipe_stage_reg
    import core_pkg::*;
#(
    parameter int CTRL_W  = DE_CTRL_W,
    parameter int DATA_W  = DE_DATA_W,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    pstage_e           state_q, state_d;
    logic              main_v_q, main_v_d;
    logic              skid_v_q, skid_v_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    logic              in_ready_s;
    logic              accept_s;
    logic              drain_s;
    logic              stall_inc_s;
    logic [1:0]        flush_inc_s;

    // Ready: with a skid buffer it comes straight from a flop, otherwise the
    // single register may refill in the same cycle it drains.
    always_comb begin
        if (SKID_EN != 0) begin
            in_ready_s = ~skid_v_q;
        end else begin
            in_ready_s = out_ready_i | ~main_v_q;
        end
        accept_s = in_valid_i & in_ready_s;
        drain_s  = main_v_q & out_ready_i;
    end

    // Next-state logic for occupancy and the main/skid entry registers.
    always_comb begin
        state_d     = state_q;
        main_v_d    = main_v_q;
        skid_v_d    = skid_v_q;
        ctrl_d      = ctrl_q;
        data_d      = data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush_i) begin
            // Data registers are left stale; the valid bits alone mask them.
            state_d  = EMPTY;
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (SKID_EN == 0) begin
            if (accept_s) begin
                main_v_d = 1'b1;
                ctrl_d   = in_ctrl_i;
                data_d   = in_data_i;
                state_d  = ONE;
            end else if (drain_s) begin
                main_v_d = 1'b0;
                state_d  = EMPTY;
            end else begin
                state_d  = state_q;
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept_s) begin
                        main_v_d = 1'b1;
                        ctrl_d   = in_ctrl_i;
                        data_d   = in_data_i;
                        state_d  = ONE;
                    end else begin
                        state_d  = EMPTY;
                    end
                end
                ONE: begin
                    if (accept_s && drain_s) begin
                        ctrl_d  = in_ctrl_i;
                        data_d  = in_data_i;
                        state_d = ONE;
                    end else if (drain_s) begin
                        main_v_d = 1'b0;
                        state_d  = EMPTY;
                    end else if (accept_s) begin
                        // Downstream stalled: park the newcomer behind main.
                        skid_v_d    = 1'b1;
                        skid_ctrl_d = in_ctrl_i;
                        skid_data_d = in_data_i;
                        state_d     = FULL;
                    end else begin
                        state_d = ONE;
                    end
                end
                FULL: begin
                    if (drain_s) begin
                        ctrl_d   = skid_ctrl_q;
                        data_d   = skid_data_q;
                        skid_v_d = 1'b0;
                        state_d  = ONE;
                    end else begin
                        state_d  = FULL;
                    end
                end
                default: begin
                    main_v_d = 1'b0;
                    skid_v_d = 1'b0;
                    state_d  = EMPTY;
                end
            endcase
        end
    end

    // Stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_v_q    <= 1'b0;
            skid_v_q    <= 1'b0;
            ctrl_q      <= {CTRL_W{1'b0}};
            data_q      <= {DATA_W{1'b0}};
            skid_ctrl_q <= {CTRL_W{1'b0}};
            skid_data_q <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            main_v_q    <= main_v_d;
            skid_v_q    <= skid_v_d;
            ctrl_q      <= ctrl_d;
            data_q      <= data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

    // Counter increments; a stall during a flush cycle is still a stall.
    always_comb begin
        stall_inc_s = main_v_q & ~out_ready_i;
        if (flush_i) begin
            flush_inc_s = held_count(main_v_q, skid_v_q);
        end else begin
            flush_inc_s = 2'd0;
        end
    end

    sat_counter #(.W(CNT_W), .INC_W(1)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (stall_inc_s),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W), .INC_W(2)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (flush_inc_s),
        .cnt_o (flush_cnt_o)
    );

    assign in_ready_o  = in_ready_s;
    assign out_valid_o = main_v_q;
    assign out_ctrl_o  = main_v_q ? ctrl_q : {CTRL_W{1'b0}};
    assign out_data_o  = data_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks of pipe_stage_reg in three builds:
//   a_* : default (skid buffer, 16-bit counters)
//   b_* : SKID_EN=0 (combinational ready), plus a random scoreboard run
//   c_* : CNT_W=4 for counter saturation
module tb_pipe_stage_reg;

    localparam int CW = 12;
    localparam int DW = 165;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_val(input string tag, input logic [191:0] got, input logic [191:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- instance A: skid buffer ----------------
    logic          a_rst, a_flush, a_iv, a_ir, a_ov, a_or;
    logic [CW-1:0] a_ictrl, a_octrl;
    logic [DW-1:0] a_idata, a_odata;
    logic [15:0]   a_stall, a_fcnt;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(a_rst), .flush_i(a_flush),
        .in_valid_i(a_iv), .in_ready_o(a_ir), .in_ctrl_i(a_ictrl), .in_data_i(a_idata),
        .out_valid_o(a_ov), .out_ready_i(a_or), .out_ctrl_o(a_octrl), .out_data_o(a_odata),
        .stall_cnt_o(a_stall), .flush_cnt_o(a_fcnt)
    );

    // ---------------- instance B: no skid ----------------
    logic          b_rst, b_flush, b_iv, b_ir, b_ov, b_or;
    logic [CW-1:0] b_ictrl, b_octrl;
    logic [DW-1:0] b_idata, b_odata;
    logic [15:0]   b_stall, b_fcnt;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(b_rst), .flush_i(b_flush),
        .in_valid_i(b_iv), .in_ready_o(b_ir), .in_ctrl_i(b_ictrl), .in_data_i(b_idata),
        .out_valid_o(b_ov), .out_ready_i(b_or), .out_ctrl_o(b_octrl), .out_data_o(b_odata),
        .stall_cnt_o(b_stall), .flush_cnt_o(b_fcnt)
    );

    // ---------------- instance C: 4-bit counters ----------------
    logic          c_rst, c_flush, c_iv, c_ir, c_ov, c_or;
    logic [CW-1:0] c_ictrl, c_octrl;
    logic [DW-1:0] c_idata, c_odata;
    logic [3:0]    c_stall, c_fcnt;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1), .CNT_W(4)) dut_c (
        .clk(clk), .rst(c_rst), .flush_i(c_flush),
        .in_valid_i(c_iv), .in_ready_o(c_ir), .in_ctrl_i(c_ictrl), .in_data_i(c_idata),
        .out_valid_o(c_ov), .out_ready_i(c_or), .out_ctrl_o(c_octrl), .out_data_o(c_odata),
        .stall_cnt_o(c_stall), .flush_cnt_o(c_fcnt)
    );

    logic [DW-1:0] sb[$];
    logic [DW-1:0] exp_data;
    int            sent, recv, cyc, underflow, seq;

    initial begin
        a_rst = 1'b1; a_flush = 1'b0; a_iv = 1'b0; a_or = 1'b0; a_ictrl = '0; a_idata = '0;
        b_rst = 1'b1; b_flush = 1'b0; b_iv = 1'b0; b_or = 1'b0; b_ictrl = '0; b_idata = '0;
        c_rst = 1'b1; c_flush = 1'b0; c_iv = 1'b0; c_or = 1'b0; c_ictrl = '0; c_idata = '0;

        // Reset held 2 cycles while upstream offers an entry.
        a_iv = 1'b1; a_idata = DW'(99); a_ictrl = 12'hFFF; a_or = 1'b1;
        tick(); tick();
        check_val("rst_valid", 192'(a_ov), 192'(0));
        check_val("rst_ctrl", 192'(a_octrl), 192'(0));
        check_val("rst_data", 192'(a_odata), 192'(0));
        check_val("rst_stall", 192'(a_stall), 192'(0));
        check_val("rst_flush", 192'(a_fcnt), 192'(0));
        check_val("rst_ready", 192'(a_ir), 192'(1));

        // Streaming 1..8, one per cycle, 1-cycle latency.
        a_rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            a_idata = DW'(i);
            a_ictrl = CW'(256 + i);
            tick();
            check_val("stream_valid", 192'(a_ov), 192'(1));
            check_val("stream_data", 192'(a_odata), 192'(i));
            check_val("stream_ctrl", 192'(a_octrl), 192'(256 + i));
        end
        a_iv = 1'b0;
        tick();
        check_val("stream_end_valid", 192'(a_ov), 192'(0));
        check_val("stream_end_ctrl", 192'(a_octrl), 192'(0));
        check_val("stream_stall", 192'(a_stall), 192'(0));

        // Skid: A accepted, then 3 stalled cycles offering B and C.
        a_iv = 1'b1; a_idata = DW'(10); a_ictrl = 12'h0A1;
        tick();
        check_val("skid_a_out", 192'(a_odata), 192'(10));
        a_or = 1'b0; a_idata = DW'(11); a_ictrl = 12'h0B2;
        tick();
        check_val("skid_full_ready", 192'(a_ir), 192'(0));
        a_idata = DW'(12); a_ictrl = 12'h0C3;
        tick(); tick();
        check_val("skid_stall3", 192'(a_stall), 192'(3));
        check_val("skid_ready_held", 192'(a_ir), 192'(0));
        check_val("skid_hold_valid", 192'(a_ov), 192'(1));
        check_val("skid_hold_data", 192'(a_odata), 192'(10));
        check_val("skid_hold_ctrl", 192'(a_octrl), 192'(12'h0A1));
        a_or = 1'b1;
        tick();
        check_val("skid_b_out", 192'(a_odata), 192'(11));
        check_val("skid_b_ctrl", 192'(a_octrl), 192'(12'h0B2));
        check_val("skid_ready_back", 192'(a_ir), 192'(1));
        tick();
        check_val("skid_c_out", 192'(a_odata), 192'(12));
        a_iv = 1'b0;
        tick();
        check_val("skid_drained", 192'(a_ov), 192'(0));
        check_val("skid_stall_final", 192'(a_stall), 192'(3));

        // Flush in FULL with an offered entry D.
        a_iv = 1'b1; a_idata = DW'(20); a_ictrl = 12'h0E4; a_or = 1'b0;
        tick();
        a_idata = DW'(21); a_ictrl = 12'h0F5;
        tick();
        check_val("flush_pre_full", 192'(a_ir), 192'(0));
        a_flush = 1'b1; a_idata = DW'(22); a_ictrl = 12'h0D6;
        tick();
        check_val("flush_valid", 192'(a_ov), 192'(0));
        check_val("flush_ctrl", 192'(a_octrl), 192'(0));
        check_val("flush_cnt2", 192'(a_fcnt), 192'(2));
        check_val("flush_stall_too", 192'(a_stall), 192'(5));
        check_val("flush_ready", 192'(a_ir), 192'(1));
        a_flush = 1'b0; a_iv = 1'b0; a_or = 1'b1;
        tick();
        check_val("flush_no_d", 192'(a_ov), 192'(0));
        // Flush while empty discards the accepted-looking input, counts nothing.
        a_flush = 1'b1; a_iv = 1'b1; a_idata = DW'(23);
        tick();
        check_val("flush_empty_valid", 192'(a_ov), 192'(0));
        check_val("flush_empty_cnt", 192'(a_fcnt), 192'(2));
        a_flush = 1'b0; a_iv = 1'b0;
        tick();
        check_val("flush_empty_no_g", 192'(a_ov), 192'(0));

        // Reset mid-stream: discards entry, clears counters, not a flush.
        a_iv = 1'b1; a_idata = DW'(30);
        tick();
        a_rst = 1'b1; a_iv = 1'b0;
        tick();
        check_val("midrst_valid", 192'(a_ov), 192'(0));
        check_val("midrst_fcnt", 192'(a_fcnt), 192'(0));
        check_val("midrst_data", 192'(a_odata), 192'(0));
        a_rst = 1'b0;

        // Saturation on the 4-bit build.
        c_rst = 1'b0; c_iv = 1'b1; c_idata = DW'(5); c_ictrl = 12'h055; c_or = 1'b0;
        tick();
        check_val("sat_start", 192'(c_stall), 192'(0));
        c_iv = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 15) check_val("sat_at15", 192'(c_stall), 192'(15));
        end
        check_val("sat_held", 192'(c_stall), 192'(15));
        check_val("sat_data_held", 192'(c_odata), 192'(5));

        // SKID_EN=0: ready follows the equation during reset.
        b_or = 1'b0;
        tick();
        check_val("b_rst_ready", 192'(b_ir), 192'(1));
        b_rst = 1'b0;
        b_iv = 1'b1; b_idata = DW'(100);
        tick();
        check_val("b_loaded", 192'(b_ov), 192'(1));
        // Keep offering; ready must mirror out_ready while full.
        seq = 101;
        for (int k = 0; k < 6; k++) begin
            b_or = k[0];
            b_idata = DW'(seq);
            #1;
            check_val("b_ready_mirror", 192'(b_ir), 192'(k[0]));
            check_val("b_out_data", 192'(b_odata), 192'(seq - 1));
            if (k[0]) seq++;
            tick();
        end

        // Random traffic on SKID_EN=0 against a scoreboard queue.
        b_rst = 1'b1; b_iv = 1'b0;
        tick();
        b_rst = 1'b0;
        sent = 0; recv = 0; cyc = 0; underflow = 0;
        while (recv < 100 && cyc < 3000) begin
            b_iv    = (sent < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
            b_or    = 1'($urandom_range(0, 1));
            b_idata = DW'(1000 + sent);
            b_ictrl = CW'(sent);
            #1;
            if (b_ov && b_or) begin
                if (sb.size() == 0) begin
                    underflow++;
                end else begin
                    exp_data = sb.pop_front();
                    check_val("sb_data", 192'(b_odata), 192'(exp_data));
                    recv++;
                end
            end
            if (b_iv && b_ir) begin
                sb.push_back(b_idata);
                sent++;
            end
            tick();
            cyc++;
        end
        check_val("sb_received", 192'(recv), 192'(100));
        check_val("sb_underflow", 192'(underflow), 192'(0));
        check_val("sb_leftover", 192'(sb.size()), 192'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
